// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StFetch,
    StDone
  } arb_state_e;

  // Width needed to hold values 0..max_val, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU-side request/response and memory-side strobe signals of the arbiter.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  // Instruction fetch port
  logic  i_req;
  word_t i_addr;
  logic  i_ack;
  word_t i_rdata;

  // Data load/store port
  logic  d_read;
  logic  d_write;
  word_t d_addr;
  word_t d_wdata;
  logic  d_ack;
  word_t d_rdata;

  // Memory port
  logic  m_read;
  logic  m_write;
  word_t m_addr;
  word_t m_wdata;
  word_t m_rdata;
  logic  m_busy;

  // Pipeline control
  logic  freeze;
  logic  err;

  // Arbiter view
  modport master (
    input  i_req, i_addr, d_read, d_write, d_addr, d_wdata, m_rdata, m_busy,
    output i_ack, i_rdata, d_ack, d_rdata, m_read, m_write, m_addr, m_wdata, freeze, err
  );

  // CPU plus memory environment view
  modport slave (
    output i_req, i_addr, d_read, d_write, d_addr, d_wdata, m_rdata, m_busy,
    input  i_ack, i_rdata, d_ack, d_rdata, m_read, m_write, m_addr, m_wdata, freeze, err
  );

endinterface

// File: rtl/mem_arbiter_busy_timer.sv
// Busy timer: counts cycles the memory holds m_busy during one access and
// flags expiry on the cycle whose edge would bring the count to TIMEOUT.
module mem_arbiter_busy_timer import mem_arbiter_pkg::*; #(
  parameter int unsigned TIMEOUT = 255  // must be >= 1
) (
  input  logic clk,
  input  logic nrst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CntW = cnt_width(TIMEOUT);

  logic [CntW-1:0] r_count;

  // Busy-cycle counter; clear has priority over counting.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CntW'(1);
    end
  end

  // The busy cycle now being counted is the TIMEOUT-th one.
  assign o_expired = i_enable && (r_count == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and data
// load/store. Data has fixed priority; one access in flight at a time.
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int unsigned TIMEOUT = 255  // max busy cycles before abort, >= 1
) (
  input  logic          clk,
  input  logic          nrst,
  mem_arbiter_if.master bus
);

  arb_state_e r_state;
  logic       r_m_read;
  logic       r_m_write;
  word_t      r_m_addr;
  word_t      r_m_wdata;
  word_t      r_i_rdata;
  word_t      r_d_rdata;
  logic       r_i_ack;
  logic       r_d_ack;
  logic       r_err;

  logic       w_in_access;
  logic       w_any_req;
  logic       w_data_req;
  logic       w_expired;

  assign w_in_access = (r_state == StData) || (r_state == StFetch);
  assign w_data_req  = bus.d_read | bus.d_write;
  assign w_any_req   = w_data_req | bus.i_req;

  // Counter restarts whenever no access is in flight, so it is zero on entry.
  mem_arbiter_busy_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_busy_timer (
    .clk       (clk),
    .nrst      (nrst),
    .i_clear   (!w_in_access),
    .i_enable  (w_in_access && bus.m_busy),
    .o_expired (w_expired)
  );

  // Arbitration FSM with registered memory strobes, acks and read data.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= StIdle;
      r_m_read  <= 1'b0;
      r_m_write <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      // Acks and err are single-cycle pulses.
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      r_err   <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_data_req) begin
            r_state   <= StData;
            r_m_addr  <= bus.d_addr;
            r_m_wdata <= bus.d_wdata;
            // A store wins when both load and store are requested.
            r_m_write <= bus.d_write;
            r_m_read  <= !bus.d_write;
          end else if (bus.i_req) begin
            r_state   <= StFetch;
            r_m_addr  <= bus.i_addr;
            r_m_read  <= 1'b1;
            r_m_write <= 1'b0;
          end
        end
        StData, StFetch: begin
          if (!bus.m_busy) begin
            r_state   <= StDone;
            r_m_read  <= 1'b0;
            r_m_write <= 1'b0;
            if (r_state == StFetch) begin
              r_i_ack   <= 1'b1;
              r_i_rdata <= bus.m_rdata;
            end else begin
              r_d_ack <= 1'b1;
              if (r_m_read) begin
                r_d_rdata <= bus.m_rdata;
              end
            end
          end else if (w_expired) begin
            r_state   <= StIdle;
            r_m_read  <= 1'b0;
            r_m_write <= 1'b0;
            r_err     <= 1'b1;
          end
        end
        StDone: begin
          // Requests are not sampled here; the requester is still dropping.
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // Stall the CPU while an access is pending or about to be accepted.
  assign bus.freeze  = w_in_access || ((r_state == StIdle) && w_any_req);

  assign bus.m_read  = r_m_read;
  assign bus.m_write = r_m_write;
  assign bus.m_addr  = r_m_addr;
  assign bus.m_wdata = r_m_wdata;
  assign bus.i_ack   = r_i_ack;
  assign bus.i_rdata = r_i_rdata;
  assign bus.d_ack   = r_d_ack;
  assign bus.d_rdata = r_d_rdata;
  assign bus.err     = r_err;

endmodule
